// File: rtl/viterbi_decoder_frame.sv
// Frame-based rate-1/2 Viterbi decoder. Each accepted code-symbol pair performs
// one add-compare-select step across all 2**(K-1) states. After a full frame the
// survivors are traced back into an output buffer, and the buffer is then streamed
// out one bit per ready/valid transfer.
module viterbi_decoder_frame #(
  parameter int K          = 3,
  parameter int G0         = 7,
  parameter int G1         = 5,
  parameter int SOFT_W     = 1,
  parameter int FRAME_LEN  = 8,
  parameter int METRIC_W   = 8,
  parameter int TERMINATED = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2*SOFT_W-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_decision,
  output logic                o_last,
  output logic [METRIC_W-1:0] o_metric
);
  localparam int SW    = K - 1;
  localparam int NS    = 1 << SW;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [K-1:0]        GM0    = G0[K-1:0];
  localparam logic [K-1:0]        GM1    = G1[K-1:0];
  localparam logic [METRIC_W-1:0] M_MAX  = '1;
  localparam logic [METRIC_W-1:0] M_INIT = {1'b1, {(METRIC_W-1){1'b0}}};
  localparam logic [SOFT_W-1:0]   S_MAX  = '1;

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [METRIC_W-1:0] b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[METRIC_W] ? M_MAX : s[METRIC_W-1:0];
  endfunction

  // Distance of one received symbol from an ideal 0 or 1 (offset-binary soft value).
  function automatic logic [SOFT_W-1:0] sym_dist(input logic e, input logic [SOFT_W-1:0] r);
    return e ? (S_MAX - r) : r;
  endfunction

  function automatic logic [METRIC_W-1:0] branch_metric(input logic [K-1:0]        reg_bits,
                                                        input logic [2*SOFT_W-1:0] r);
    logic e0, e1;
    logic [SOFT_W:0] d;
    e0 = ^(GM0 & reg_bits);
    e1 = ^(GM1 & reg_bits);
    d  = {1'b0, sym_dist(e0, r[2*SOFT_W-1:SOFT_W])} + {1'b0, sym_dist(e1, r[SOFT_W-1:0])};
    return METRIC_W'(d);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ACS, S_TRACE, S_OUT} state_t;

  state_t              state;
  logic [METRIC_W-1:0] pm [NS];
  logic [NS-1:0]       surv [FRAME_LEN];
  logic [FRAME_LEN-1:0] obuf;
  logic [CNT_W-1:0]    sym_cnt, tr_cnt, out_idx, nxt_idx;
  logic                tr_first;
  logic [SW-1:0]       tr_state, tr_cur, best_state;
  logic [METRIC_W-1:0] off_acc;
  logic [METRIC_W-1:0] pm_src [NS];
  logic [METRIC_W-1:0] pm_new [NS];
  logic [METRIC_W-1:0] pm_min, best_metric;
  logic [NS-1:0]       sel;
  logic                accept;

  assign accept  = i_valid & o_ready;
  assign nxt_idx = out_idx + 1'b1;
  assign tr_cur  = tr_first ? best_state : tr_state;

  // The first symbol of a frame always starts from the initial metric set.
  always_comb begin
    for (int s = 0; s < NS; s++)
      pm_src[s] = (state != S_IDLE) ? pm[s] : ((s == 0) ? '0 : M_INIT);
  end

  // Add-compare-select for every next state; ties keep the LSB-0 predecessor.
  always_comb begin
    logic [SW-1:0]       nsv, p0, p1;
    logic [METRIC_W-1:0] c0, c1;
    nsv    = '0;
    p0     = '0;
    p1     = '0;
    c0     = '0;
    c1     = '0;
    pm_min = M_MAX;
    sel    = '0;
    for (int s = 0; s < NS; s++) begin
      nsv       = SW'(s);
      p0        = {nsv[SW-2:0], 1'b0};
      p1        = {nsv[SW-2:0], 1'b1};
      c0        = sat_add(pm_src[p0], branch_metric({nsv[SW-1], p0}, i_data));
      c1        = sat_add(pm_src[p1], branch_metric({nsv[SW-1], p1}, i_data));
      sel[s]    = (c1 < c0);
      pm_new[s] = (c1 < c0) ? c1 : c0;
      if (pm_new[s] < pm_min) pm_min = pm_new[s];
    end
  end

  // Traceback start: state 0 for terminated frames, else lowest-index best metric.
  always_comb begin
    best_state  = '0;
    best_metric = pm[0];
    if (TERMINATED == 0) begin
      for (int s = 1; s < NS; s++) begin
        if (pm[s] < best_metric) begin
          best_metric = pm[s];
          best_state  = SW'(s);
        end
      end
    end
  end

  // Frame FSM: ACS per accepted symbol, traceback into obuf, then handshake output.
  // off_acc sums the per-step normalisation offsets so o_metric reports the true
  // cost of the winning path rather than its normalised (always minimal) value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_decision <= 1'b0;
      o_last     <= 1'b0;
      o_metric   <= '0;
      for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : M_INIT;
      for (int f = 0; f < FRAME_LEN; f++) surv[f] <= '0;
      obuf       <= '0;
      sym_cnt    <= '0;
      tr_cnt     <= '0;
      out_idx    <= '0;
      tr_first   <= 1'b0;
      tr_state   <= '0;
      off_acc    <= '0;
    end else begin
      case (state)
        S_IDLE, S_ACS: begin
          if (accept) begin
            for (int s = 0; s < NS; s++) pm[s] <= pm_new[s] - pm_min;
            surv[sym_cnt] <= sel;
            off_acc <= (state == S_IDLE) ? pm_min : sat_add(off_acc, pm_min);
            if (sym_cnt == CNT_W'(FRAME_LEN-1)) begin
              state    <= S_TRACE;
              o_ready  <= 1'b0;
              sym_cnt  <= '0;
              tr_cnt   <= CNT_W'(FRAME_LEN-1);
              tr_first <= 1'b1;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
              state   <= S_ACS;
            end
          end
        end
        S_TRACE: begin
          obuf[tr_cnt] <= tr_cur[SW-1];
          tr_state     <= {tr_cur[SW-2:0], surv[tr_cnt][tr_cur]};
          tr_first     <= 1'b0;
          if (tr_first) o_metric <= sat_add(pm[tr_cur], off_acc);
          if (tr_cnt == '0) state <= S_OUT;
          else              tr_cnt <= tr_cnt - 1'b1;
        end
        S_OUT: begin
          if (!o_valid) begin
            o_valid    <= 1'b1;
            o_decision <= obuf[0];
            o_last     <= 1'b0;
            out_idx    <= '0;
          end else if (i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_ready <= 1'b1;
              state   <= S_IDLE;
            end else begin
              out_idx    <= nxt_idx;
              o_decision <= obuf[nxt_idx];
              o_last     <= (nxt_idx == CNT_W'(FRAME_LEN-1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_decoder_frame.sv
// Directed bench for viterbi_decoder_frame (K=3, G=7/5, hard decision, 8-bit frames).
// Expected decoded bits are queued when a frame is driven and checked as they leave.
module tb_viterbi_decoder_frame;
  localparam int FL = 8;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, o_ready, o_valid, i_ready, o_decision, o_last;
  logic [1:0] i_data;
  logic [7:0] o_metric;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  bit tog_run;

  typedef struct packed {
    logic       d;
    logic       last;
    logic [7:0] metric;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  localparam logic [2*FL-1:0] T1 = 16'b11_01_01_00_01_01_00_10;
  localparam logic [2*FL-1:0] T2 = 16'b11_10_00_10_00_10_00_10;
  localparam logic [2*FL-1:0] T3 = 16'b11_01_11_00_01_01_00_10;
  localparam logic [FL-1:0]   B1 = 8'b1101_1010;
  localparam logic [FL-1:0]   B2 = 8'b1010_1010;

  viterbi_decoder_frame #(
    .K(3), .G0(7), .G1(5), .SOFT_W(1), .FRAME_LEN(FL), .METRIC_W(8), .TERMINATED(0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_decision(o_decision), .o_last(o_last), .o_metric(o_metric)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference rate-1/2 encoder (G0=111, G1=101), first bit in the MSB.
  function automatic logic [2*FL-1:0] encode(input logic [FL-1:0] msg);
    logic [1:0]      st;
    logic            b;
    logic [2*FL-1:0] res;
    st  = 2'b00;
    res = '0;
    for (int j = 0; j < FL; j++) begin
      b = msg[FL-1-j];
      res[2*FL-1-2*j -: 2] = {b ^ st[1] ^ st[0], b ^ st[0]};
      st = {b, st[1]};
    end
    return res;
  endfunction

  // Output monitor: every valid cycle is compared with the queue head; a bit is
  // popped only when it is actually transferred.
  always @(negedge i_clk) begin
    if (i_rst) begin
      check("rst_o_valid", o_valid, 1'b0);
    end else if (o_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", o_valid, 1'b0);
      end else begin
        mon_e = sb[0];
        check("decision", o_decision, mon_e.d);
        check("last", o_last, mon_e.last);
        if (i_ready) begin
          if (mon_e.last) check("metric", o_metric, mon_e.metric);
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic send_sym(input logic [1:0] s);
    int n;
    n       = 0;
    i_data  = s;
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", o_ready, 1'b1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [2*FL-1:0] syms, input logic [FL-1:0] bits,
                            input logic [7:0] metric, input int nsym, input bit gaps);
    exp_t e;
    for (int j = 0; j < nsym; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
      send_sym(syms[2*FL-1-2*j -: 2]);
    end
    if (nsym == FL) begin
      for (int j = 0; j < FL; j++) begin
        e.d      = bits[FL-1-j];
        e.last   = (j == FL-1);
        e.metric = metric;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input int start_out);
    int n;
    n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 400) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (n >= 400) check("frame_timeout", o_ready, 1'b1);
    check("bit_count", n_out - start_out, FL);
  endtask

  initial begin
    int n;
    int base;
    logic [FL-1:0] msg;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 2'b00;
    i_ready = 1'b1;
    tog_run = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_o_ready", o_ready, 1'b1);
    check("rst_o_valid0", o_valid, 1'b0);
    check("rst_o_decision", o_decision, 1'b0);
    check("rst_o_last", o_last, 1'b0);
    check("rst_o_metric", o_metric, 8'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Clean frame, back-to-back, with latency and ready-drop checks
    base = n_out;
    send_frame(T1, B1, 8'd0, FL, 1'b0);
    check("ready_fall", o_ready, 1'b0);
    n = 0;
    while (!o_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("latency", n, FL + 1);
    wait_done(base);
    check("metric_held_t1", o_metric, 8'd0);
    check("ready_back", o_ready, 1'b1);

    // Single channel error in the third symbol
    base = n_out;
    send_frame(T3, B1, 8'd1, FL, 1'b0);
    wait_done(base);
    check("metric_held_t3", o_metric, 8'd1);

    // Reset after four symbols abandons the frame
    send_frame(T1, B1, 8'd0, 4, 1'b0);
    i_rst = 1'b1;
    #1;
    check("midrst_o_ready", o_ready, 1'b1);
    check("midrst_o_metric", o_metric, 8'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    base = n_out;
    send_frame(T2, B2, 8'd0, FL, 1'b0);
    wait_done(base);

    // Alternating pattern with input gaps and output back-pressure
    base    = n_out;
    tog_run = 1'b1;
    fork
      begin
        send_frame(T2, B2, 8'd0, FL, 1'b1);
        wait_done(base);
        tog_run = 1'b0;
      end
      begin
        while (tog_run) begin
          repeat (2) @(posedge i_clk);
          #1;
          i_ready = ~i_ready;
        end
      end
    join
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;

    // Symbols offered while busy are ignored; next frame still decodes
    base = n_out;
    send_frame(T2, B2, 8'd0, FL, 1'b0);
    i_valid = 1'b1;
    repeat (12) begin
      i_data = 2'($urandom);
      check("ready_low_busy", o_ready, 1'b0);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    wait_done(base);
    base = n_out;
    send_frame(T1, B1, 8'd0, FL, 1'b0);
    wait_done(base);

    // Random error-free messages through the reference encoder
    for (int r = 0; r < 3; r++) begin
      msg  = FL'($urandom);
      base = n_out;
      send_frame(encode(msg), msg, 8'd0, FL, 1'b0);
      wait_done(base);
    end

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
